// File: rtl/jtframe_mc2_i2s.sv
// Philips I2S serialiser for the Multicore 2 audio DAC, clocked entirely from clk_sys.
// Optional master clock output enabled by defining JTFRAME_I2S_MCLK_EN.
module jtframe_mc2_i2s #(
  parameter int   BCLK_DIV   = 4,
  parameter logic SIGNED_SND = 1'b1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] snd_left,
  input  logic [15:0] snd_right,
  output logic        sample_req,
  output logic        i2s_mclk,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data
);

  localparam int DW = (BCLK_DIV < 2) ? 1 : $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);

  generate
    if (BCLK_DIV < 2) begin : g_bad_div
      $error("jtframe_mc2_i2s: BCLK_DIV must be >= 2");
    end
  endgenerate

  logic [DW-1:0] div;
  logic [5:0]    slot;
  logic [15:0]   sh_l, sh_r;

  logic          tc, fe, bit_nx;
  logic [5:0]    slot_nx;
  logic [4:0]    pos;
  logic [15:0]   word;

  function automatic logic [15:0] fmt(input logic [15:0] x);
    return SIGNED_SND ? x : {~x[15], x[14:0]};
  endfunction

  always_comb begin
    tc      = (div == DIV_TC);
    fe      = tc & i2s_bclk;
    slot_nx = slot + 6'd1;
    pos     = slot_nx[4:0];
    word    = slot_nx[5] ? sh_r : sh_l;
    bit_nx  = 1'b0;
    // p=0 is the Philips one-bit delay; p=17..31 pad the 32-bit slot with zeros
    if (pos >= 5'd1 && pos <= 5'd16)
      bit_nx = word[4'(5'd16 - pos)];
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else if (tc) begin
      div      <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div      <= div + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      slot       <= '0;
      i2s_lrclk  <= 1'b0;
      i2s_data   <= 1'b0;
      sample_req <= 1'b0;
      sh_l       <= '0;
      sh_r       <= '0;
    end else begin
      sample_req <= 1'b0;
      if (fe) begin
        slot      <= slot_nx;
        i2s_lrclk <= slot_nx[5];
        i2s_data  <= bit_nx;
        // both words latched together at frame start so a frame never mixes samples
        if (slot_nx == 6'd0) begin
          sh_l       <= fmt(snd_left);
          sh_r       <= fmt(snd_right);
          sample_req <= 1'b1;
        end
      end
    end
  end

`ifdef JTFRAME_I2S_MCLK_EN
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) i2s_mclk <= 1'b0;
    else     i2s_mclk <= ~i2s_mclk;
  end
`else
  assign i2s_mclk = 1'b0;
`endif

endmodule
